pc_fetch_unit: RTL and testbench

Program-counter and instruction-fetch controller for the RISC-V core. It sits directly downstream of the branch decision logic and consumes its branch_enable output, together with the jal/jalr controls, to select the next PC. It runs a request/acknowledge fetch from instruction memory and presents one instruction at a time to decode/execute, holding it until that instruction retires.

---
 rtl/pc_fetch_unit_pkg.sv | 15 +
 rtl/pc_fetch_unit_next_pc_calc.sv | 38 +++
 rtl/pc_fetch_unit.sv | 119 +++++++++++
 tb/tb_pc_fetch_unit.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and constants for the PC / fetch unit.
// State encoding, NOP word and default reset PC.
package pc_fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_fetch_unit_next_pc_calc.sv
// next_pc_calc: combinational next-PC select (jalr > jal > branch > +4).
// Ports: pc, imm, rs1_data, jal, jalr, branch_enable -> next_pc, misaligned.
module next_pc_calc #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_data,
  input  logic            jal,
  input  logic            jalr,
  input  logic            branch_enable,
  output logic [XLEN-1:0] next_pc,
  output logic            misaligned
);

  localparam logic [XLEN-1:0] CLR_B0 = {{(XLEN-1){1'b1}}, 1'b0};

  logic [XLEN-1:0] jalr_tgt;
  logic [XLEN-1:0] rel_tgt;
  logic [XLEN-1:0] seq_tgt;

  assign jalr_tgt = (rs1_data + imm) & CLR_B0;
  assign rel_tgt  = pc + imm;
  assign seq_tgt  = pc + XLEN'(4);

  // jal and jalr may both be set; jalr must win.
  always_comb begin
    next_pc = seq_tgt;
    if (jalr) begin
      next_pc = jalr_tgt;
    end else if (jal || branch_enable) begin
      next_pc = rel_tgt;
    end
  end

  assign misaligned = next_pc[1];

endmodule

// File: rtl/pc_fetch_unit.sv
// PC and instruction-fetch controller: req/ack fetch, one instr in flight.
// Ports: clk, rst_n, stall, redirects in; imem req/ack; instr/pc/trap out.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            branch_enable,
  input  logic            jal,
  input  logic            jalr,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_data,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instr,
  output logic            instr_valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            misalign_trap
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic            valid_q, valid_d;
  logic            req_q, req_d;
  logic            trap_q, trap_d;

  logic [XLEN-1:0] next_pc;
  logic            next_mis;

  next_pc_calc #(
    .XLEN(XLEN)
  ) u_npc (
    .pc           (pc_q),
    .imm          (imm),
    .rs1_data     (rs1_data),
    .jal          (jal),
    .jalr         (jalr),
    .branch_enable(branch_enable),
    .next_pc      (next_pc),
    .misaligned   (next_mis)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    req_d   = req_q;
    trap_d  = trap_q;
    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
        req_d   = 1'b1;
      end
      ST_FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          valid_d = 1'b1;
          req_d   = 1'b0;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (!stall) begin
          valid_d = 1'b0;
          if (next_mis) begin
            // PC stays on the faulting instruction.
            trap_d  = 1'b1;
            state_d = ST_HALT;
          end else begin
            pc_d    = next_pc;
            req_d   = 1'b1;
            state_d = ST_FETCH;
          end
        end
      end
      ST_HALT: begin
        req_d   = 1'b0;
        valid_d = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= XLEN'(RESET_PC);
      instr_q <= XLEN'(NOP_INSTR);
      valid_q <= 1'b0;
      req_q   <= 1'b0;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      req_q   <= req_d;
      trap_q  <= trap_d;
    end
  end

  assign imem_req      = req_q;
  assign imem_addr     = pc_q;
  assign instr         = instr_q;
  assign instr_valid   = valid_q;
  assign pc            = pc_q;
  assign pc_plus4      = pc_q + XLEN'(4);
  assign misalign_trap = trap_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit.
// Drives #1 after posedge, checks before next edge.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        branch_enable;
  logic        jal;
  logic        jalr;
  logic [31:0] imm;
  logic [31:0] rs1_data;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        misalign_trap;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_fetch_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .branch_enable(branch_enable),
    .jal          (jal),
    .jalr         (jalr),
    .imm          (imm),
    .rs1_data     (rs1_data),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .misalign_trap(misalign_trap)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] w);
    imem_ack   = 1'b1;
    imem_rdata = w;
    step();
    imem_ack   = 1'b0;
  endtask

  task automatic retire(input logic j, input logic jr,
                        input logic br, input logic [31:0] im,
                        input logic [31:0] r1);
    jal = j; jalr = jr; branch_enable = br;
    imm = im; rs1_data = r1; stall = 1'b0;
    step();
    jal = 0; jalr = 0; branch_enable = 0;
    imm = 0; rs1_data = 0;
  endtask

  initial begin
    rst_n = 0; stall = 0; branch_enable = 0;
    jal = 0; jalr = 0; imm = 0; rs1_data = 0;
    imem_ack = 0; imem_rdata = 0;
    step(); step();
    chk("rst_pc",    pc, 32'h0);
    chk("rst_req",   {31'd0, imem_req}, 32'd0);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_trap",  {31'd0, misalign_trap}, 32'd0);

    // 1: first fetch, zero-wait ack
    rst_n = 1;
    step();
    chk("t1_req",  {31'd0, imem_req}, 32'd1);
    chk("t1_addr", imem_addr, 32'h0);
    fetch(32'h0050_0093);
    chk("t1_valid", {31'd0, instr_valid}, 32'd1);
    chk("t1_instr", instr, 32'h0050_0093);
    chk("t1_pc",    pc, 32'h0);
    chk("t1_noreq", {31'd0, imem_req}, 32'd0);

    // 2: sequential and wrap
    retire(1, 0, 0, 32'h10, 0);
    chk("t2_jal_addr", imem_addr, 32'h10);
    chk("t2_req", {31'd0, imem_req}, 32'd1);
    chk("t2_novalid", {31'd0, instr_valid}, 32'd0);
    fetch(32'h13);
    retire(0, 0, 0, 32'h0, 0);
    chk("t2_seq", imem_addr, 32'h14);
    fetch(32'h13);
    retire(0, 0, 1, 32'hFFFF_FFE8, 0);
    chk("t2_top", imem_addr, 32'hFFFF_FFFC);
    fetch(32'h13);
    chk("t2_p4wrap", pc_plus4, 32'h0);
    retire(0, 0, 0, 32'h0, 0);
    chk("t2_wrap", imem_addr, 32'h0);
    fetch(32'h13);
    retire(1, 0, 0, 32'h10, 0);
    fetch(32'h0000_0063);

    // 3: stalled branch
    branch_enable = 1; imm = 32'hFFFF_FFF8; stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t3_pc",    pc, 32'h10);
      chk("t3_instr", instr, 32'h0000_0063);
      chk("t3_valid", {31'd0, instr_valid}, 32'd1);
    end
    retire(0, 0, 1, 32'hFFFF_FFF8, 0);
    chk("t3_addr", imem_addr, 32'h08);
    fetch(32'h0000_0067);

    // 4: jalr beats jal
    jal = 1; jalr = 1; rs1_data = 32'h1001; imm = 32'd3;
    #1;
    chk("t4_p4", pc_plus4, 32'h0C);
    retire(1, 1, 0, 32'd3, 32'h1001);
    chk("t4_addr", imem_addr, 32'h1004);

    // 6: slow ack, then reset mid-fetch
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6_addr", imem_addr, 32'h1004);
      chk("t6_req",  {31'd0, imem_req}, 32'd1);
    end
    fetch(32'hABCD_0013);
    chk("t6_instr", instr, 32'hABCD_0013);
    retire(0, 0, 0, 32'h0, 0);
    rst_n = 0;
    step();
    chk("t6_rstreq", {31'd0, imem_req}, 32'd0);
    rst_n = 1; imem_ack = 1; imem_rdata = 32'hFFFF_FFFF;
    step();
    imem_ack = 0;
    chk("t6_valid", {31'd0, instr_valid}, 32'd0);
    chk("t6_nop",   instr, 32'h0000_0013);
    chk("t6_addr0", imem_addr, 32'h0);
    chk("t6_req1",  {31'd0, imem_req}, 32'd1);

    // 5: misaligned jal -> halt
    fetch(32'h0060_006F);
    retire(1, 0, 0, 32'd6, 0);
    chk("t5_trap",  {31'd0, misalign_trap}, 32'd1);
    chk("t5_valid", {31'd0, instr_valid}, 32'd0);
    chk("t5_pc",    pc, 32'h0);
    for (int i = 0; i < 5; i++) begin
      imem_ack = 1; jal = 1; imm = 32'h8;
      step();
      chk("t5_req",  {31'd0, imem_req}, 32'd0);
      chk("t5_hold", {31'd0, misalign_trap}, 32'd1);
    end
    imem_ack = 0; jal = 0; imm = 0;
    rst_n = 0;
    step();
    chk("t5_clr", {31'd0, misalign_trap}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
